// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the UART ClkDiv configuration sequencer.
package clk_div_ctrl_pkg;

  localparam int unsigned DIV_RATIO = 8;
  localparam int unsigned PRESC_W   = 6;

  localparam logic [PRESC_W-1:0] PRESC_32 = 6'd32;
  localparam logic [PRESC_W-1:0] PRESC_16 = 6'd16;
  localparam logic [PRESC_W-1:0] PRESC_8  = 6'd8;

  typedef enum logic [2:0] {
    STARTUP,
    RUN,
    DRAIN,
    GATE_PRE,
    GATE_POST
  } div_ctrl_state_e;

  typedef struct packed {
    logic                 legal;
    logic [DIV_RATIO-1:0] ratio;
  } rx_div_t;

  // RX ClkDiv ratio is 32/prescale; anything outside {32,16,8} is flagged illegal.
  function automatic rx_div_t presc_to_rx_div(input logic [PRESC_W-1:0] presc);
    rx_div_t r;
    r = '0;
    case (presc)
      PRESC_32: r = '{legal: 1'b1, ratio: DIV_RATIO'(1)};
      PRESC_16: r = '{legal: 1'b1, ratio: DIV_RATIO'(2)};
      PRESC_8:  r = '{legal: 1'b1, ratio: DIV_RATIO'(4)};
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clk_div_ctrl.sv
// Sequences baud-ratio changes into the TX/RX ClkDiv instances so a ratio
// never changes while a divider is enabled.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_RATIO,
  parameter int unsigned GATE_CYCLES = 4,
  parameter int unsigned DRAIN_TMO   = 1024,
  parameter int unsigned DEF_TX_DIV  = 8,
  parameter int unsigned DEF_PRESC   = 32
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [DIV_W-1:0]   i_cfg_div,
  input  logic [PRESC_W-1:0] i_cfg_presc,
  input  logic               i_tx_busy,
  input  logic               i_rx_busy,
  output logic [DIV_W-1:0]   o_tx_div_ratio,
  output logic [DIV_W-1:0]   o_rx_div_ratio,
  output logic               o_tx_clk_en,
  output logic               o_rx_clk_en,
  output logic               o_cfg_done,
  output logic               o_cfg_err
);

  localparam int unsigned GCNT_W = $clog2(GATE_CYCLES + 1);
  localparam int unsigned DCNT_W = $clog2(DRAIN_TMO + 1);

  localparam rx_div_t          DEF_RX_D = presc_to_rx_div(PRESC_W'(DEF_PRESC));
  localparam logic [DIV_W-1:0] DEF_RX   = DIV_W'(DEF_RX_D.ratio);
  localparam logic [DIV_W-1:0] DEF_TX   = DIV_W'(DEF_TX_DIV);

  localparam logic [GCNT_W-1:0] GATE_LAST  = GCNT_W'(GATE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_TMO - 1);

  div_ctrl_state_e   state;
  logic              clk_en;
  logic              done;
  logic              err;
  logic [DIV_W-1:0]  tx_ratio;
  logic [DIV_W-1:0]  rx_ratio;
  logic [DIV_W-1:0]  shadow_tx;
  logic [DIV_W-1:0]  shadow_rx;
  logic [GCNT_W-1:0] gate_cnt;
  logic [DCNT_W-1:0] drain_cnt;

  rx_div_t req_rx;
  logic    req_legal;
  logic    uart_idle;

  assign req_rx    = presc_to_rx_div(i_cfg_presc);
  assign req_legal = req_rx.legal & (i_cfg_div != '0);
  assign uart_idle = ~i_tx_busy & ~i_rx_busy;

  assign o_cfg_ready    = (state == RUN);
  assign o_tx_div_ratio = tx_ratio;
  assign o_rx_div_ratio = rx_ratio;
  assign o_tx_clk_en    = clk_en;
  assign o_rx_clk_en    = clk_en;
  assign o_cfg_done     = done;
  assign o_cfg_err      = err;

  // Sequencer: both dividers share one enable, so they are always gated together.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= STARTUP;
      clk_en    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tx_ratio  <= DEF_TX;
      rx_ratio  <= DEF_RX;
      shadow_tx <= '0;
      shadow_rx <= '0;
      gate_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        STARTUP: begin
          state     <= RUN;
          clk_en    <= 1'b1;
          gate_cnt  <= '0;
          drain_cnt <= '0;
        end
        RUN: begin
          if (i_cfg_valid) begin
            if (!req_legal) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              shadow_tx <= i_cfg_div;
              shadow_rx <= DIV_W'(req_rx.ratio);
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end
        // Idle is checked before the timeout so a late idle still applies the request.
        DRAIN: begin
          if (uart_idle) begin
            clk_en   <= 1'b0;
            gate_cnt <= '0;
            state    <= GATE_PRE;
          end else if (drain_cnt == DRAIN_LAST) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= RUN;
          end else begin
            drain_cnt <= drain_cnt + DCNT_W'(1);
          end
        end
        GATE_PRE: begin
          if (gate_cnt == GATE_LAST) begin
            tx_ratio <= shadow_tx;
            rx_ratio <= shadow_rx;
            gate_cnt <= '0;
            state    <= GATE_POST;
          end else begin
            gate_cnt <= gate_cnt + GCNT_W'(1);
          end
        end
        GATE_POST: begin
          if (gate_cnt == GATE_LAST) begin
            clk_en    <= 1'b1;
            done      <= 1'b1;
            drain_cnt <= '0;
            state     <= RUN;
          end else begin
            gate_cnt <= gate_cnt + GCNT_W'(1);
          end
        end
        default: begin
          clk_en <= 1'b0;
          state  <= STARTUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: request table plus directed drain,
// timeout, back-to-back and mid-sequence reset sequences.
module tb_clk_div_ctrl;
  import clk_div_ctrl_pkg::*;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned G     = 4;
  localparam int unsigned TMO   = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [5:0]       cfg_presc = '0;
  logic             tx_busy = 1'b0;
  logic             rx_busy = 1'b0;
  logic             ready;
  logic [DIV_W-1:0] tx_ratio;
  logic [DIV_W-1:0] rx_ratio;
  logic             tx_en;
  logic             rx_en;
  logic             done;
  logic             err;

  clk_div_ctrl #(
    .DIV_W(DIV_W), .GATE_CYCLES(G), .DRAIN_TMO(TMO), .DEF_TX_DIV(8), .DEF_PRESC(32)
  ) dut (
    .i_ref_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(valid), .o_cfg_ready(ready),
    .i_cfg_div(cfg_div), .i_cfg_presc(cfg_presc), .i_tx_busy(tx_busy), .i_rx_busy(rx_busy),
    .o_tx_div_ratio(tx_ratio), .o_rx_div_ratio(rx_ratio), .o_tx_clk_en(tx_en),
    .o_rx_clk_en(rx_en), .o_cfg_done(done), .o_cfg_err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic             err;
    logic [DIV_W-1:0] tx;
    logic [DIV_W-1:0] rx;
  } exp_t;

  typedef struct {
    logic [DIV_W-1:0] div;
    logic [5:0]       presc;
    logic             err;
    logic [DIV_W-1:0] tx;
    logic [DIV_W-1:0] rx;
  } vec_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous monitor: scoreboard on done, enable-gate length, ratio stability.
  logic             prev_en = 1'b0;
  int               low_run = 0;
  bit               in_gate = 1'b0;
  logic [DIV_W-1:0] prev_tx = '0;
  logic [DIV_W-1:0] prev_rx = '0;
  exp_t             mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      low_run = 0;
      in_gate = 1'b0;
      prev_en = 1'b0;
    end else begin
      chk("en_match", rx_en, tx_en);
      if (tx_ratio !== prev_tx || rx_ratio !== prev_rx) chk("ratio_change_while_en", tx_en, 0);
      if (!tx_en) begin
        if (prev_en) in_gate = 1'b1;
        low_run++;
      end else begin
        if (in_gate) chk("gate_len", low_run, 2 * G);
        in_gate = 1'b0;
        low_run = 0;
      end
      prev_en = tx_en;
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          mon_e = sb.pop_front();
          chk("done_err", err, mon_e.err);
          chk("done_tx", tx_ratio, mon_e.tx);
          chk("done_rx", rx_ratio, mon_e.rx);
        end
      end
    end
    prev_tx = tx_ratio;
    prev_rx = rx_ratio;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max, output int at, output bit en_dropped);
    en_dropped = 1'b0;
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!tx_en) en_dropped = 1'b1;
      if (done) begin
        at = cyc;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  // Called just after a rising edge; returns the index of the acceptance edge.
  task automatic issue(input logic [DIV_W-1:0] div, input logic [5:0] presc,
                       input exp_t e, output int acc);
    for (int i = 0; i < 20 && !ready; i++) tick();
    chk("ready_before_req", ready, 1);
    valid     = 1'b1;
    cfg_div   = div;
    cfg_presc = presc;
    sb.push_back(e);
    tick();
    acc   = cyc;
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[8];
    int   acc, acc1, at, d1, r, lows;
    bit   dropped;
    exp_t e;

    v[0] = '{8'd12,  6'd16, 1'b0, 8'd12,  8'd2};
    v[1] = '{8'd0,   6'd16, 1'b1, 8'd12,  8'd2};
    v[2] = '{8'd5,   6'd20, 1'b1, 8'd12,  8'd2};
    v[3] = '{8'd255, 6'd8,  1'b0, 8'd255, 8'd4};
    v[4] = '{8'd1,   6'd32, 1'b0, 8'd1,   8'd1};
    v[5] = '{8'd3,   6'd0,  1'b1, 8'd1,   8'd1};
    v[6] = '{8'd7,   6'd63, 1'b1, 8'd1,   8'd1};
    v[7] = '{8'd200, 6'd16, 1'b0, 8'd200, 8'd2};

    // Reset state and startup
    repeat (3) @(negedge clk);
    chk("rst_tx_ratio", tx_ratio, 8);
    chk("rst_rx_ratio", rx_ratio, 1);
    chk("rst_en", {tx_en, rx_en}, 0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("startup_ready", ready, 0);
    chk("startup_en", tx_en, 0);
    tick();
    chk("run_en", {tx_en, rx_en}, 2'b11);
    chk("run_ready", ready, 1);

    // Request table with idle UART
    foreach (v[i]) begin
      e = '{v[i].err, v[i].tx, v[i].rx};
      issue(v[i].div, v[i].presc, e, acc);
      wait_done(3 * G + 10, at, dropped);
      chk($sformatf("vec%0d_latency", i), at - acc, v[i].err ? 0 : 2 * G + 1);
      chk($sformatf("vec%0d_en_dropped", i), dropped, !v[i].err);
      chk($sformatf("vec%0d_tx", i), tx_ratio, v[i].tx);
      chk($sformatf("vec%0d_rx", i), rx_ratio, v[i].rx);
      tick();
    end

    // RX busy for 50 cycles holds the sequence in DRAIN with enables up
    rx_busy = 1'b1;
    issue(8'd10, 6'd32, '{1'b0, 8'd10, 8'd1}, acc);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!tx_en) lows++;
    end
    chk("drain_en_held", lows, 0);
    chk("drain_ready", ready, 0);
    rx_busy = 1'b0;
    r = cyc;
    wait_done(3 * G + 10, at, dropped);
    chk("drain_release_latency", at - r, 2 * G + 1);
    tick();

    // TX busy stuck: abort after TMO cycles in DRAIN, nothing changes
    tx_busy = 1'b1;
    issue(8'd9, 6'd8, '{1'b1, 8'd10, 8'd1}, acc);
    wait_done(TMO + 10, at, dropped);
    chk("tmo_latency", at - acc, TMO);
    chk("tmo_en_dropped", dropped, 0);
    tick();

    // Idle arrives on the same edge the timeout would fire: apply wins
    issue(8'd6, 6'd16, '{1'b0, 8'd6, 8'd2}, acc);
    repeat (TMO - 1) tick();
    tx_busy = 1'b0;
    wait_done(3 * G + 10, at, dropped);
    chk("idle_wins_latency", at - acc, TMO + 2 * G);
    tick();

    // Back-to-back: valid held across done
    valid     = 1'b1;
    cfg_div   = 8'd20;
    cfg_presc = 6'd32;
    sb.push_back('{1'b0, 8'd20, 8'd1});
    tick();
    acc1      = cyc;
    cfg_div   = 8'd21;
    cfg_presc = 6'd8;
    sb.push_back('{1'b0, 8'd21, 8'd4});
    wait_done(3 * G + 10, d1, dropped);
    chk("b2b_first_latency", d1 - acc1, 2 * G + 1);
    chk("b2b_ready_at_done", ready, 1);
    tick();
    valid = 1'b0;
    wait_done(3 * G + 10, at, dropped);
    chk("b2b_second_latency", at - d1, 2 * G + 2);
    chk("b2b_tx", tx_ratio, 21);
    chk("b2b_rx", rx_ratio, 4);
    tick();

    // Reset during GATE_POST discards the sequence
    issue(8'd33, 6'd16, '{1'b0, 8'd33, 8'd2}, acc);
    repeat (G + 2) tick();
    chk("pre_rst_en", tx_en, 0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_tx", tx_ratio, 8);
    chk("midrst_rx", rx_ratio, 1);
    chk("midrst_en", {tx_en, rx_en}, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_en", tx_en, 1);
    chk("post_rst_ready", ready, 1);
    repeat (3 * G) tick();

    // Recovery after reset
    issue(8'd4, 6'd8, '{1'b0, 8'd4, 8'd4}, acc);
    wait_done(3 * G + 10, at, dropped);
    chk("recover_latency", at - acc, 2 * G + 1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
